// File: rtl/ddr_demux_1to2_pkg.sv
// Shared definitions for the DDR 1:2 receive demux: width helper, FSM encoding and
// the training words also used by the transmit-side training generator.
package ddr_demux_1to2_pkg;

  localparam int unsigned BW_DEFAULT = 6;

  function automatic int unsigned data_width(input int unsigned bw);
    return bw + 15;
  endfunction

  localparam int unsigned DW_DEFAULT = data_width(BW_DEFAULT);

  localparam logic signed [DW_DEFAULT-1:0] TP1_DEFAULT = 21'sh0AAAA;
  localparam logic signed [DW_DEFAULT-1:0] TP2_DEFAULT = 21'sh15555;

  typedef logic [1:0] state_t;

  localparam state_t SEARCH = 2'd0;
  localparam state_t CHECK  = 2'd1;
  localparam state_t LOCKED = 2'd2;

endpackage

// File: rtl/ddr_demux_1to2_if.sv
// Data/status bundle between the DDR pad side (master) and the demux (slave).
interface ddr_demux_1to2_if
  import ddr_demux_1to2_pkg::*;
#(
  parameter int unsigned BW = 6
);
  localparam int unsigned DW = data_width(BW);

  logic signed [DW-1:0] IN;
  logic                 TRAIN;
  logic signed [DW-1:0] OUT1;
  logic signed [DW-1:0] OUT2;
  logic                 VALID;
  logic                 LOCK;
  logic                 SWAP;

  modport master (
    output IN, TRAIN,
    input  OUT1, OUT2, VALID, LOCK, SWAP
  );

  modport slave (
    input  IN, TRAIN,
    output OUT1, OUT2, VALID, LOCK, SWAP
  );

endinterface

// File: rtl/ddr_demux_1to2_capture.sv
// Dual-edge capture of the DDR stream and the registered word-pairing mux.
module ddr_demux_1to2_capture #(
  parameter int unsigned DW = 21
) (
  input  logic                 CLK,
  input  logic                 RES,
  input  logic signed [DW-1:0] in_word,
  input  logic                 swap,
  output logic signed [DW-1:0] h,
  output logic signed [DW-1:0] lp,
  output logic signed [DW-1:0] out1,
  output logic signed [DW-1:0] out2
);

  // High-phase word is still on the bus when CLK falls.
  always_ff @(negedge CLK or posedge RES) begin
    if (RES) begin
      h <= '0;
    end else begin
      h <= in_word;
    end
  end

  // At the rising edge in_word is the low-phase word L(n); lp keeps it as L(n-1).
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      lp   <= '0;
      out1 <= '0;
      out2 <= '0;
    end else begin
      lp <= in_word;
      if (swap) begin
        out1 <= lp;
        out2 <= h;
      end else begin
        out1 <= h;
        out2 <= in_word;
      end
    end
  end

endmodule

// File: rtl/ddr_demux_1to2.sv
// DDR 1:2 receive demux: rebuilds word pairs and aligns the pairing on a training pattern.
module ddr_demux_1to2
  import ddr_demux_1to2_pkg::*;
#(
  parameter int unsigned                BW       = 6,
  parameter logic signed [BW+14:0]      TP1      = (BW+15)'(TP1_DEFAULT),
  parameter logic signed [BW+14:0]      TP2      = (BW+15)'(TP2_DEFAULT),
  parameter int unsigned                LOCK_CNT = 4
) (
  input logic        CLK,
  input logic        RES,
  ddr_demux_1to2_if.slave bus
);

  localparam int unsigned DW      = data_width(BW);
  localparam logic [3:0]  LockCnt = 4'(LOCK_CNT);

  logic signed [DW-1:0] h, lp;
  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 swap_q, swap_d;
  logic                 valid_q, valid_d;
  logic                 m_n, m_s, m;

  ddr_demux_1to2_capture #(
    .DW (DW)
  ) u_capture (
    .CLK     (CLK),
    .RES     (RES),
    .in_word (bus.IN),
    .swap    (swap_q),
    .h       (h),
    .lp      (lp),
    .out1    (bus.OUT1),
    .out2    (bus.OUT2)
  );

  // Normal pairing checks H(n)/L(n); offset pairing checks L(n-1)/H(n).
  assign m_n = (h == TP1) && (bus.IN == TP2);
  assign m_s = (lp == TP1) && (h == TP2);
  assign m   = swap_q ? m_s : m_n;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    swap_d  = swap_q;
    unique case (state_q)
      SEARCH: begin
        cnt_d = '0;
        if (bus.TRAIN && (m_n || m_s)) begin
          swap_d  = !m_n;
          cnt_d   = 4'd1;
          state_d = (LockCnt == 4'd1) ? LOCKED : CHECK;
        end
      end
      CHECK: begin
        if (bus.TRAIN && m) begin
          cnt_d = (cnt_q >= LockCnt) ? LockCnt : cnt_q + 4'd1;
          if (cnt_q + 4'd1 == LockCnt) begin
            state_d = LOCKED;
          end
        end else begin
          cnt_d   = '0;
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        if (bus.TRAIN && !m) begin
          cnt_d   = '0;
          state_d = SEARCH;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = SEARCH;
      end
    endcase
  end

  assign valid_d = (state_d == LOCKED) && !bus.TRAIN;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q <= SEARCH;
      cnt_q   <= '0;
      swap_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      swap_q  <= swap_d;
      valid_q <= valid_d;
    end
  end

  assign bus.LOCK  = (state_q == LOCKED);
  assign bus.VALID = valid_q;
  assign bus.SWAP  = swap_q;

endmodule

// File: tb/tb_ddr_demux_1to2.sv
// Directed bench for ddr_demux_1to2: reset, normal/offset alignment, broken training,
// data path after lock and lock loss.
module tb_ddr_demux_1to2;
  import ddr_demux_1to2_pkg::*;

  localparam logic signed [20:0] T1 = 21'sh0AAAA;
  localparam logic signed [20:0] T2 = 21'sh15555;

  logic CLK;
  logic RES;
  int   n_cmp;
  int   n_bad;

  ddr_demux_1to2_if #(.BW(6)) bus ();

  ddr_demux_1to2 #(
    .BW       (6),
    .TP1      (T1),
    .TP2      (T2),
    .LOCK_CNT (4)
  ) dut (
    .CLK (CLK),
    .RES (RES),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk_w(input string tag, input logic signed [20:0] obs,
                       input logic signed [20:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; drives one DDR cycle and returns at the next posedge+1.
  task automatic step(input logic signed [20:0] hi, input logic signed [20:0] lo,
                      input logic train);
    bus.IN    = hi;
    bus.TRAIN = train;
    @(negedge CLK);
    #1;
    bus.IN = lo;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic lock, input logic valid,
                           input logic swap);
    chk_n({tag, " LOCK"},  {3'b000, bus.LOCK},  {3'b000, lock});
    chk_n({tag, " VALID"}, {3'b000, bus.VALID}, {3'b000, valid});
    chk_n({tag, " SWAP"},  {3'b000, bus.SWAP},  {3'b000, swap});
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    RES       = 1'b1;
    bus.IN    = '0;
    bus.TRAIN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_w("reset OUT1", bus.OUT1, 21'sd0);
    chk_w("reset OUT2", bus.OUT2, 21'sd0);
    chk_flags("reset", 1'b0, 1'b0, 1'b0);
    RES = 1'b0;

    // Unlocked pass-through in normal pairing
    step(21'sd3, -21'sd4, 1'b0);
    chk_w("idle OUT1", bus.OUT1, 21'sd3);
    chk_w("idle OUT2", bus.OUT2, -21'sd4);

    // Mid-cycle reset clears immediately and holds while IN toggles
    #2;
    RES = 1'b1;
    #1;
    chk_w("midreset OUT1", bus.OUT1, 21'sd0);
    chk_w("midreset OUT2", bus.OUT2, 21'sd0);
    @(posedge CLK);
    #1;
    step(21'sd7, 21'sd8, 1'b1);
    chk_w("heldreset OUT1", bus.OUT1, 21'sd0);
    chk_w("heldreset OUT2", bus.OUT2, 21'sd0);
    chk_flags("heldreset", 1'b0, 1'b0, 1'b0);
    RES = 1'b0;

    // Normal alignment
    step(T1, T2, 1'b1);
    chk_n("norm1 state", {2'b00, dut.state_q}, 4'd1);
    chk_n("norm1 cnt", dut.cnt_q, 4'd1);
    step(T1, T2, 1'b1);
    step(T1, T2, 1'b1);
    chk_flags("norm3", 1'b0, 1'b0, 1'b0);
    step(T1, T2, 1'b1);
    chk_flags("norm4", 1'b1, 1'b0, 1'b0);
    chk_w("norm4 OUT1", bus.OUT1, 21'sh0AAAA);
    chk_w("norm4 OUT2", bus.OUT2, 21'sh15555);
    step(T1, T2, 1'b1);
    step(T1, T2, 1'b1);
    chk_flags("norm6", 1'b1, 1'b0, 1'b0);
    chk_n("norm6 cnt sat", dut.cnt_q, 4'd4);
    step(T1, T2, 1'b0);
    chk_flags("valid", 1'b1, 1'b1, 1'b0);

    // Data path after lock
    step(-21'sd5, 21'sd7, 1'b0);
    chk_w("data1 OUT1", bus.OUT1, -21'sd5);
    chk_w("data1 OUT2", bus.OUT2, 21'sd7);
    step(21'sh0FFFFF, 21'sh100000, 1'b0);
    chk_w("data2 OUT1", bus.OUT1, 21'sh0FFFFF);
    chk_w("data2 OUT2", bus.OUT2, 21'sh100000);
    chk_flags("data2", 1'b1, 1'b1, 1'b0);

    // Lock loss on a wrong training pair
    step(T1, 21'sd5, 1'b1);
    chk_flags("loss", 1'b0, 1'b0, 1'b0);
    chk_n("loss state", {2'b00, dut.state_q}, 4'd0);

    // Broken training: 3 good, one corrupted low word, then 4 fresh
    step(T1, T2, 1'b1);
    step(T1, T2, 1'b1);
    step(T1, T2, 1'b1);
    step(T1, 21'sd0, 1'b1);
    chk_n("broken state", {2'b00, dut.state_q}, 4'd0);
    chk_n("broken cnt", dut.cnt_q, 4'd0);
    chk_flags("broken", 1'b0, 1'b0, 1'b0);
    step(T1, T2, 1'b1);
    step(T1, T2, 1'b1);
    step(T1, T2, 1'b1);
    chk_flags("fresh3", 1'b0, 1'b0, 1'b0);
    step(T1, T2, 1'b1);
    chk_flags("fresh4", 1'b1, 1'b0, 1'b0);

    // Offset alignment: drop lock, then shift the pairs by half a cycle
    step(T1, 21'sd5, 1'b1);
    chk_flags("loss2", 1'b0, 1'b0, 1'b0);
    step(T2, T1, 1'b1);
    chk_flags("off1", 1'b0, 1'b0, 1'b0);
    step(T2, T1, 1'b1);
    chk_flags("off2", 1'b0, 1'b0, 1'b1);
    step(T2, T1, 1'b1);
    step(T2, T1, 1'b1);
    chk_flags("off4", 1'b0, 1'b0, 1'b1);
    step(T2, T1, 1'b1);
    chk_flags("off5", 1'b1, 1'b0, 1'b1);
    chk_w("off5 OUT1", bus.OUT1, 21'sh0AAAA);
    chk_w("off5 OUT2", bus.OUT2, 21'sh15555);
    step(21'sd11, 21'sd22, 1'b0);
    chk_flags("offdata1", 1'b1, 1'b1, 1'b1);
    chk_w("offdata1 OUT2", bus.OUT2, 21'sd11);
    step(21'sd33, 21'sd44, 1'b0);
    chk_w("offdata2 OUT1", bus.OUT1, 21'sd22);
    chk_w("offdata2 OUT2", bus.OUT2, 21'sd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
